axi_dma_wr_master: RTL and testbench

AXI_DMA_WR_MASTER -- requirements
Module: axi_dma_wr_master

---
 rtl/axi_dma_wr_master_if.sv | 59 +++++
 rtl/axi_dma_wr_master.sv | 119 +++++++++++
 tb/tb_axi_dma_wr_master.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dma_wr_master_if.sv
// Bundles the command, source-stream, completion and AXI write-channel signals
// of the DMA write master; master = the DMA block, slave = its surroundings.
interface axi_dma_wr_master_if #(
  parameter int AXI_ID_WD   = 2,
  parameter int AXI_DATA_WD = 32,
  parameter int AXI_ADDR_WD = 32
);
  logic                     i_cmd_valid;
  logic                     o_cmd_ready;
  logic [AXI_ADDR_WD-1:0]   i_cmd_addr;
  logic [7:0]               i_cmd_len;
  logic [AXI_ID_WD-1:0]     i_cmd_id;

  logic [AXI_DATA_WD-1:0]   i_s_data;
  logic                     i_s_valid;
  logic                     o_s_ready;

  logic                     o_done;
  logic [1:0]               o_done_resp;

  logic [AXI_ADDR_WD-1:0]   M_AXI_AWADDR;
  logic [AXI_ID_WD-1:0]     M_AXI_AWID;
  logic [1:0]               M_AXI_AWBURST;
  logic [2:0]               M_AXI_AWSIZE;
  logic [7:0]               M_AXI_AWLEN;
  logic                     M_AXI_AWVALID;
  logic                     M_AXI_AWREADY;

  logic [AXI_DATA_WD-1:0]   M_AXI_WDATA;
  logic [AXI_DATA_WD/8-1:0] M_AXI_WSTRB;
  logic                     M_AXI_WLAST;
  logic                     M_AXI_WVALID;
  logic                     M_AXI_WREADY;

  logic [AXI_ID_WD-1:0]     M_AXI_BID;
  logic [1:0]               M_AXI_BRESP;
  logic                     M_AXI_BVALID;
  logic                     M_AXI_BREADY;

  modport master (
    input  i_cmd_valid, i_cmd_addr, i_cmd_len, i_cmd_id,
    input  i_s_data, i_s_valid,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
    output o_cmd_ready, o_s_ready, o_done, o_done_resp,
    output M_AXI_AWADDR, M_AXI_AWID, M_AXI_AWBURST, M_AXI_AWSIZE, M_AXI_AWLEN, M_AXI_AWVALID,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_BREADY
  );

  modport slave (
    output i_cmd_valid, i_cmd_addr, i_cmd_len, i_cmd_id,
    output i_s_data, i_s_valid,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
    input  o_cmd_ready, o_s_ready, o_done, o_done_resp,
    input  M_AXI_AWADDR, M_AXI_AWID, M_AXI_AWBURST, M_AXI_AWSIZE, M_AXI_AWLEN, M_AXI_AWVALID,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_BREADY
  );
endinterface

// File: rtl/axi_dma_wr_master.sv
// Single-burst AXI write master: each accepted command becomes one INCR burst
// whose beats are passed straight through from the source stream.
module axi_dma_wr_master #(
  parameter int AXI_ID_WD   = 2,
  parameter int AXI_DATA_WD = 32,
  parameter int AXI_ADDR_WD = 32
) (
  input  logic                M_AXI_ACLK,
  input  logic                M_AXI_ARESETN,
  axi_dma_wr_master_if.master bus
);

  localparam logic [2:0] AW_SIZE = 3'($clog2(AXI_DATA_WD / 8));

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

  state_t                 state_reg, state_next;
  logic [AXI_ADDR_WD-1:0] addr_reg;
  logic [7:0]             len_reg;
  logic [AXI_ID_WD-1:0]   id_reg;
  logic [7:0]             beat_reg;
  logic                   done_reg;
  logic [1:0]             resp_reg;

  logic cmd_ready, aw_valid, w_valid, s_ready, b_ready, w_last;
  logic cmd_fire, aw_fire, w_fire, b_fire;
  logic unused_bid;

  assign unused_bid = ^bus.M_AXI_BID;

  assign w_last   = (state_reg == W) && (beat_reg == len_reg);
  assign cmd_fire = cmd_ready && bus.i_cmd_valid;
  assign aw_fire  = aw_valid && bus.M_AXI_AWREADY;
  assign w_fire   = w_valid && bus.M_AXI_WREADY;
  assign b_fire   = b_ready && bus.M_AXI_BVALID;

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    aw_valid   = 1'b0;
    w_valid    = 1'b0;
    s_ready    = 1'b0;
    b_ready    = 1'b0;
    case (state_reg)
      IDLE: begin
        // Not ready while reset is held, so nothing is accepted during reset.
        cmd_ready = M_AXI_ARESETN;
        if (bus.i_cmd_valid && M_AXI_ARESETN) state_next = AW;
      end
      AW: begin
        aw_valid = 1'b1;
        if (bus.M_AXI_AWREADY) state_next = W;
      end
      W: begin
        w_valid = bus.i_s_valid;
        s_ready = bus.M_AXI_WREADY;
        if (bus.i_s_valid && bus.M_AXI_WREADY && w_last) state_next = B;
      end
      B: begin
        b_ready = 1'b1;
        if (bus.M_AXI_BVALID) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      addr_reg <= '0;
      len_reg  <= '0;
      id_reg   <= '0;
      beat_reg <= '0;
      done_reg <= 1'b0;
      resp_reg <= 2'b00;
    end else begin
      done_reg <= b_fire;
      if (cmd_fire) begin
        addr_reg <= bus.i_cmd_addr;
        len_reg  <= bus.i_cmd_len;
        id_reg   <= bus.i_cmd_id;
      end
      // The wrap after beat 255 is harmless: the burst has already ended.
      if (aw_fire) begin
        beat_reg <= '0;
      end else if (w_fire) begin
        beat_reg <= beat_reg + 8'd1;
      end
      if (b_fire) resp_reg <= bus.M_AXI_BRESP;
    end
  end

  assign bus.o_cmd_ready   = cmd_ready;
  assign bus.o_s_ready     = s_ready;
  assign bus.o_done        = done_reg;
  assign bus.o_done_resp   = resp_reg;

  assign bus.M_AXI_AWADDR  = addr_reg;
  assign bus.M_AXI_AWID    = id_reg;
  assign bus.M_AXI_AWBURST = 2'b01;
  assign bus.M_AXI_AWSIZE  = AW_SIZE;
  assign bus.M_AXI_AWLEN   = len_reg;
  assign bus.M_AXI_AWVALID = aw_valid;

  assign bus.M_AXI_WDATA   = bus.i_s_data;
  assign bus.M_AXI_WSTRB   = '1;
  assign bus.M_AXI_WLAST   = w_last;
  assign bus.M_AXI_WVALID  = w_valid;

  assign bus.M_AXI_BREADY  = b_ready;

endmodule

// File: tb/tb_axi_dma_wr_master.sv
// Transaction-level bench for axi_dma_wr_master: each command is played out with
// random stalls and every AW/W/B observation is compared with what the command implies.
module tb_axi_dma_wr_master;

  localparam int IDW = 2;
  localparam int DW  = 32;
  localparam int AW  = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  axi_dma_wr_master_if #(.AXI_ID_WD(IDW), .AXI_DATA_WD(DW), .AXI_ADDR_WD(AW)) bus();

  axi_dma_wr_master #(.AXI_ID_WD(IDW), .AXI_DATA_WD(DW), .AXI_ADDR_WD(AW)) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rstn),
    .bus          (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [1:0] last_resp = 2'b00;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.i_cmd_valid   = 1'b0;
    bus.i_cmd_addr    = '0;
    bus.i_cmd_len     = '0;
    bus.i_cmd_id      = '0;
    bus.i_s_data      = '0;
    bus.i_s_valid     = 1'b0;
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BID     = '0;
    bus.M_AXI_BRESP   = 2'b00;
    bus.M_AXI_BVALID  = 1'b0;
  endtask

  // One command end to end. Entered and left just after a falling edge; on a normal
  // finish the current cycle is the one where o_done is high.
  task automatic run_cmd(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] id,
                         input int aw_stall, input int b_delay, input logic [1:0] resp,
                         input int p_rdy, input bit timed, input int rst_beat);
    int unsigned t0;
    int          beats;
    int          guard;
    logic [31:0] word;
    bit          fire;

    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_addr  = addr;
    bus.i_cmd_len   = len;
    bus.i_cmd_id    = id;
    #1;
    guard = 0;
    while (!bus.o_cmd_ready && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    check("cmd_ready", 64'(bus.o_cmd_ready), 64'd1);
    t0 = cyc;

    for (int i = 0; i <= aw_stall; i++) begin
      @(negedge clk);
      bus.i_cmd_valid   = (i == 0) ? 1'b0 : 1'($urandom_range(1));
      bus.i_cmd_addr    = $urandom;
      bus.i_cmd_len     = 8'($urandom);
      bus.i_cmd_id      = 2'($urandom);
      bus.i_s_valid     = 1'($urandom_range(1));
      bus.i_s_data      = $urandom;
      bus.M_AXI_WREADY  = 1'($urandom_range(1));
      bus.M_AXI_AWREADY = (i == aw_stall);
      #1;
      if (i == 0) begin
        check("aw_after_fire", 64'(bus.M_AXI_AWVALID), 64'd1);
        check("done_clear", 64'(bus.o_done), 64'd0);
        check("resp_hold", 64'(bus.o_done_resp), 64'(last_resp));
      end
      check("aw_valid", 64'(bus.M_AXI_AWVALID), 64'd1);
      check("aw_addr", 64'(bus.M_AXI_AWADDR), 64'(addr));
      check("aw_len", 64'(bus.M_AXI_AWLEN), 64'(len));
      check("aw_id", 64'(bus.M_AXI_AWID), 64'(id));
      check("aw_burst", 64'(bus.M_AXI_AWBURST), 64'd1);
      check("aw_size", 64'(bus.M_AXI_AWSIZE), 64'd2);
      check("aw_no_wvalid", 64'(bus.M_AXI_WVALID), 64'd0);
      check("aw_no_sready", 64'(bus.o_s_ready), 64'd0);
      check("aw_no_bready", 64'(bus.M_AXI_BREADY), 64'd0);
      check("aw_cmd_busy", 64'(bus.o_cmd_ready), 64'd0);
    end

    beats = 0;
    guard = 0;
    word  = $urandom;
    while (beats <= int'(len)) begin
      @(negedge clk);
      bus.i_cmd_valid   = 1'b0;
      bus.M_AXI_AWREADY = 1'b0;
      bus.i_s_valid     = timed || ($urandom_range(99) < p_rdy);
      bus.M_AXI_WREADY  = timed || ($urandom_range(99) < p_rdy);
      bus.i_s_data      = word;
      if (rst_beat >= 0 && beats == rst_beat) rstn = 1'b0;
      #1;
      fire = bus.i_s_valid && bus.M_AXI_WREADY;
      check("w_valid", 64'(bus.M_AXI_WVALID), 64'(bus.i_s_valid));
      check("w_sready", 64'(bus.o_s_ready), 64'(bus.M_AXI_WREADY));
      check("w_last", 64'(bus.M_AXI_WLAST), 64'(beats == int'(len)));
      check("w_strb", 64'(bus.M_AXI_WSTRB), 64'hF);
      check("w_no_awvalid", 64'(bus.M_AXI_AWVALID), 64'd0);
      if (fire) check("w_data", 64'(bus.M_AXI_WDATA), 64'(word));
      if (!rstn) begin
        @(negedge clk);
        bus.i_s_valid    = 1'b1;
        bus.M_AXI_WREADY = 1'b1;
        bus.M_AXI_AWREADY = 1'b1;
        bus.M_AXI_BVALID = 1'b1;
        #1;
        check("rst_awvalid", 64'(bus.M_AXI_AWVALID), 64'd0);
        check("rst_wvalid", 64'(bus.M_AXI_WVALID), 64'd0);
        check("rst_bready", 64'(bus.M_AXI_BREADY), 64'd0);
        check("rst_sready", 64'(bus.o_s_ready), 64'd0);
        check("rst_cmd_ready", 64'(bus.o_cmd_ready), 64'd0);
        check("rst_done", 64'(bus.o_done), 64'd0);
        @(negedge clk);
        idle_inputs();
        rstn = 1'b1;
        #1;
        check("rst_rel_ready", 64'(bus.o_cmd_ready), 64'd1);
        check("rst_rel_done", 64'(bus.o_done), 64'd0);
        check("rst_rel_resp", 64'(bus.o_done_resp), 64'd0);
        check("rst_rel_wvalid", 64'(bus.M_AXI_WVALID), 64'd0);
        last_resp = 2'b00;
        return;
      end
      if (fire) begin
        beats++;
        word = $urandom;
      end
      guard++;
      if (guard > 5000) begin
        check("w_timeout", 64'(beats), 64'(int'(len) + 1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "W phase bound expired");
      end
    end

    for (int i = 0; i <= b_delay; i++) begin
      @(negedge clk);
      bus.i_s_valid    = 1'($urandom_range(1));
      bus.M_AXI_WREADY = 1'($urandom_range(1));
      bus.i_cmd_valid  = 1'b0;
      bus.M_AXI_BVALID = (i == b_delay);
      bus.M_AXI_BRESP  = (i == b_delay) ? resp : 2'($urandom);
      #1;
      check("b_ready", 64'(bus.M_AXI_BREADY), 64'd1);
      check("b_no_wvalid", 64'(bus.M_AXI_WVALID), 64'd0);
      check("b_no_sready", 64'(bus.o_s_ready), 64'd0);
      check("b_no_done", 64'(bus.o_done), 64'd0);
      check("b_no_awvalid", 64'(bus.M_AXI_AWVALID), 64'd0);
    end

    @(negedge clk);
    bus.M_AXI_BVALID = 1'b1;
    bus.M_AXI_BRESP  = 2'($urandom);
    bus.i_s_valid    = 1'b0;
    bus.M_AXI_WREADY = 1'b0;
    #1;
    check("done", 64'(bus.o_done), 64'd1);
    check("done_resp", 64'(bus.o_done_resp), 64'(resp));
    check("done_cmd_ready", 64'(bus.o_cmd_ready), 64'd1);
    check("done_no_bready", 64'(bus.M_AXI_BREADY), 64'd0);
    if (timed) check("period", 64'(cyc - t0), 64'(int'(len) + 4));
    bus.M_AXI_BVALID = 1'b0;
    last_resp = resp;
    $display("cmd addr=%08h len=%0d id=%0d resp=%0d done at +%0d cycles", addr, len, id, resp, cyc - t0);
  endtask

  initial begin
    idle_inputs();
    bus.i_s_valid     = 1'b1;
    bus.M_AXI_WREADY  = 1'b1;
    bus.i_cmd_valid   = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_cmd_ready", 64'(bus.o_cmd_ready), 64'd0);
    check("reset_awvalid", 64'(bus.M_AXI_AWVALID), 64'd0);
    check("reset_wvalid", 64'(bus.M_AXI_WVALID), 64'd0);
    check("reset_bready", 64'(bus.M_AXI_BREADY), 64'd0);
    check("reset_done", 64'(bus.o_done), 64'd0);
    check("reset_resp", 64'(bus.o_done_resp), 64'd0);
    @(negedge clk);
    idle_inputs();
    rstn = 1'b1;
    #1;
    check("idle_ready", 64'(bus.o_cmd_ready), 64'd1);

    run_cmd(32'h100, 8'd0, 2'd1, 0, 0, 2'b00, 100, 1'b1, -1);
    @(negedge clk);
    run_cmd(32'h2000, 8'd3, 2'd2, 0, 0, 2'b01, 50, 1'b0, -1);
    @(negedge clk);
    run_cmd(32'h40, 8'd2, 2'd0, 5, 0, 2'b00, 100, 1'b0, -1);
    @(negedge clk);
    run_cmd(32'h80, 8'd1, 2'd3, 0, 3, 2'b10, 100, 1'b0, -1);
    @(negedge clk);
    run_cmd(32'h300, 8'd7, 2'd1, 0, 0, 2'b00, 100, 1'b0, 1);
    run_cmd(32'h400, 8'd1, 2'd2, 0, 0, 2'b00, 100, 1'b1, -1);
    @(negedge clk);
    run_cmd(32'h1000, 8'd255, 2'd0, 0, 0, 2'b00, 100, 1'b1, -1);
    run_cmd(32'h0, 8'd0, 2'd1, 0, 0, 2'b11, 100, 1'b1, -1);

    for (int n = 0; n < 25; n++) begin
      logic [7:0] rlen;
      rlen = ($urandom_range(3) == 0) ? 8'($urandom_range(255, 16)) : 8'($urandom_range(15));
      if ($urandom_range(1) == 1) @(negedge clk);
      run_cmd($urandom & 32'hFFFF_FFFC, rlen, 2'($urandom), int'($urandom_range(4)),
              int'($urandom_range(4)), 2'($urandom), int'($urandom_range(90, 30)), 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
